lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//   Load/store initiator between the pipeline MEM stage and the data memory (i_addr/i_wdata/i_bmask/i_wren/o_rdata).
//   Accepts one RV32 load/store per handshake; generates lane mask, lane-shifted write data, word-aligned address.
//   Extracts and sign/zero-extends load data and returns a response. Misaligned handling is set by the macro under CONFIGURATION.
// PARAMETERS
//   ADDR_W  11  memory byte-address width (word index = addr[ADDR_W-1:2])
//   DATA_W  32  data width; fixed 32, 4 byte lanes
// PORTS
//   i_clk          in   1       clock, all state on rising edge
//   i_reset        in   1       asynchronous, active-low reset
//   i_req_valid    in   1       request present
//   o_req_ready    out  1       block idle, request accepted when valid&ready
//   i_req_store    in   1       1=store, 0=load
//   i_req_funct3   in   3       RV32 funct3: [1:0] size (00 B, 01 H, 10 W, 11 illegal), [2] unsigned (loads)
//   i_req_addr     in   ADDR_W  byte address
//   i_req_wdata    in   32      store data, right-justified
//   o_rsp_valid    out  1       response present; held until i_rsp_ready
//   i_rsp_ready    in   1       consumer accepts response
//   o_rsp_rdata    out  32      extended load data; 0 for stores/errors
//   o_rsp_err      out  1       misaligned (macro off) or illegal-size request
//   o_mem_addr     out  ADDR_W  word-aligned address, [1:0]=00
//   o_mem_wdata    out  32      lane-positioned write data
//   o_mem_bmask    out  4       absolute byte-lane enables
//   o_mem_wren     out  1       write strobe, one cycle per written word
//   i_mem_rdata    in   32      read data, valid the cycle after o_mem_addr is presented
// BEHAVIOUR
//   Reset: state IDLE; o_req_ready=1; o_rsp_valid, o_rsp_err, o_mem_wren=0; o_mem_addr, o_mem_wdata, o_mem_bmask, o_rsp_rdata=0.
//   Reset mid-operation: abort immediately; no further o_mem_wren (pending second store half dropped); response lost.
//   FSM: IDLE -> ACC0 -> [ACC1] -> [DONE] -> RESP -> IDLE. o_req_ready=1 only in IDLE.
//   Lane math: off=addr[1:0]; m={0001,0011,1111}[size]; M8=m<<off; D64=wdata<<(8*off).
//     Word0: mask M8[3:0], data D64[31:0]. Word1 (addr+4): mask M8[7:4], data D64[63:32].
//   Split = M8[7:4]!=0. Word1 address wraps modulo 2^ADDR_W.
//   ACC0: drive word0; wren=1 if store. ACC1 (split only): drive word1; loads capture word0.
//   DONE (loads only): capture last word; R={w1,w0}>>(8*off); byte/half sign-extended unless funct3[2]; W passed through.
//   Stores skip DONE. o_mem_bmask=0 and o_mem_wren=0 outside ACC0/ACC1.
//   Latency, accept at edge N; o_rsp_valid rises in cycle:
//     aligned store N+2, split store N+3, aligned load N+3, split load N+4, error N+1.
//   RESP: outputs registered and stable while i_rsp_ready=0. Leave on i_rsp_ready. No new request accepted in same cycle.
//   size=11: o_rsp_err=1, no memory access, regardless of macro.
// CONFIGURATION
//   LSU_MISALIGN_SPLIT_EN defined: split accesses execute as two memory cycles as above; err only for size=11.
//   Not defined: any split access -> IDLE->RESP, o_rsp_err=1, o_rsp_rdata=0, memory untouched.
//     ACC1 state and word0 capture register are compiled out.
// STRUCTURE
//   lsu_pkg:
//     lsu_state_e {IDLE,ACC0,ACC1,DONE,RESP}
//     size encodings SZ_B/SZ_H/SZ_W
//     funct3 constants LB..LHU/SB..SW
//     function size_mask(size)
//   Sub-module lsu_align (combinational):
//     store: M8/D64 generation
//     load: {w1,w0} shift plus sign/zero extension
//   lsu_ctrl: FSM and registers.
// TESTING
//   SW 0xDEADBEEF @0x00C, then LW @0x00C -> wren 1 cycle, mask 1111, addr 0x00C; rsp_rdata=DEADBEEF at N+3.
//   SB 0x12345678 @0x00D -> mask 0010, wdata 0x00007800; then LB @0x00D -> 0x00000078, LBU of 0xF0 byte -> 0x000000F0, LB -> 0xFFFFFFF0.
//   SH 0xABCD @0x012 -> mask 1100, wdata 0xABCD0000; LH @0x012 -> 0xFFFFABCD, LHU -> 0x0000ABCD.
//   SW 0xCAFEF00D @0x015:
//     macro on -> word 0x014 mask 1110 data FEF00D00, then 0x018 mask 0001 data 000000CA; LW @0x015 -> CAFEF00D at N+4.
//     macro off -> err=1 at N+1, no wren.
//   SW split @0x7FE (macro on) -> second word at 0x000 (wrap); funct3=011 -> err, no memory access.
//   i_rsp_ready=0 for 3 cycles in RESP -> outputs stable, o_req_ready=0; assert i_reset mid split store after ACC0 -> no ACC1 write, IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and constants for the load/store unit.
//                - lsu_state_e : controller states
//                - SZ_*        : funct3[1:0] access-size encodings
//                - LB..LHU/SB..SW : RV32 funct3 values
//                - size_mask() : byte-lane enables of a right-justified access
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC0 = 3'd1,
        ACC1 = 3'd2,
        DONE = 3'd3,
        RESP = 3'd4
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;   // illegal size

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Lane enables of an access starting at lane 0; illegal size enables nothing.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl_if
//  Description : Request / response / data-memory bundle of the LSU.
//                Signal prefixes are seen from the LSU (i_ = into the LSU).
//                modport slave  : the LSU itself
//                modport master : pipeline + memory side (driver of i_*)
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_ctrl_if #(
    parameter int ADDR_W = 11
);
    // request
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_store;
    logic [2:0]        i_req_funct3;
    logic [ADDR_W-1:0] i_req_addr;
    logic [31:0]       i_req_wdata;
    // response
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [31:0]       o_rsp_rdata;
    logic              o_rsp_err;
    // data memory
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [3:0]        o_mem_bmask;
    logic              o_mem_wren;
    logic [31:0]       i_mem_rdata;

    modport slave (
        input  i_req_valid, i_req_store, i_req_funct3, i_req_addr, i_req_wdata,
        input  i_rsp_ready, i_mem_rdata,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren
    );

    modport master (
        output i_req_valid, i_req_store, i_req_funct3, i_req_addr, i_req_wdata,
        output i_rsp_ready, i_mem_rdata,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren
    );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational lane alignment for the LSU.
//                Store side: 8-bit lane mask and 64-bit lane-shifted data
//                spanning word0 (low half) and word1 (high half).
//                Load side : shifts {w1,w0} down by the byte offset and
//                sign/zero-extends byte and half results.
//  Ports       : i_st_size/i_st_off/i_st_wdata -> o_st_m8/o_st_d64
//                i_ld_funct3/i_ld_off/i_ld_w0/i_ld_w1 -> o_ld_data
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_wdata,
    output logic [7:0]  o_st_m8,
    output logic [63:0] o_st_d64,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_ld_w0,
    input  logic [31:0] i_ld_w1,
    output logic [31:0] o_ld_data
);

    logic [3:0]  w_lane_en;
    logic [31:0] w_wdata_masked;
    logic [31:0] w_ld_word;

    assign w_lane_en = size_mask(i_st_size);

    // Lanes not being written carry zeros rather than stray upper bytes.
    assign w_wdata_masked = i_st_wdata & {{8{w_lane_en[3]}}, {8{w_lane_en[2]}},
                                          {8{w_lane_en[1]}}, {8{w_lane_en[0]}}};

    assign o_st_m8  = {4'b0000, w_lane_en} << i_st_off;
    assign o_st_d64 = {32'h0000_0000, w_wdata_masked} << {i_st_off, 3'b000};

    assign w_ld_word = 32'({i_ld_w1, i_ld_w0} >> {i_ld_off, 3'b000});

    always_comb begin
        o_ld_data = 32'h0000_0000;
        case (i_ld_funct3[1:0])
            SZ_B:    o_ld_data = i_ld_funct3[2] ? {24'h000000, w_ld_word[7:0]}
                                                : {{24{w_ld_word[7]}}, w_ld_word[7:0]};
            SZ_H:    o_ld_data = i_ld_funct3[2] ? {16'h0000, w_ld_word[15:0]}
                                                : {{16{w_ld_word[15]}}, w_ld_word[15:0]};
            SZ_W:    o_ld_data = w_ld_word;
            default: o_ld_data = 32'h0000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : RV32 load/store initiator between the MEM stage and a
//                word-wide data memory with a one-cycle read latency.
//                One request per handshake; response held until consumed.
//  Ports       : i_clk, i_reset (async, active low)
//                bus (lsu_ctrl_if.slave): request, response, memory port
//  Parameters  : ADDR_W byte-address width, DATA_W data width (32)
//  Config      : LSU_MISALIGN_SPLIT_EN - when defined, accesses crossing a
//                word boundary run as two memory cycles; otherwise they are
//                answered immediately with o_rsp_err and never touch memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic       i_clk,
    input  logic       i_reset,
    lsu_ctrl_if.slave  bus
);

    lsu_state_e         state_q, state_d;
    logic               store_q, store_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         off_q, off_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_bmask_q, mem_bmask_d;
    logic               mem_wren_q, mem_wren_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [7:0]         w_m8;
    logic [63:0]        w_d64;
    logic               w_split;
    logic [31:0]        w_ld_w0;
    logic [31:0]        w_ld_w1;
    logic [31:0]        w_ld_data;

`ifdef LSU_MISALIGN_SPLIT_EN
    // Second-word lane info is latched at accept so ACC1 needs no re-alignment.
    logic               split_q, split_d;
    logic [3:0]         hi_mask_q, hi_mask_d;
    logic [31:0]        hi_data_q, hi_data_d;
    logic [31:0]        word0_q, word0_d;

    assign w_ld_w0 = split_q ? word0_q : bus.i_mem_rdata;
    assign w_ld_w1 = bus.i_mem_rdata;
`else
    logic               w_unused_hi;

    assign w_unused_hi = ^w_d64[63:32];
    assign w_ld_w0     = bus.i_mem_rdata;
    assign w_ld_w1     = 32'h0000_0000;
`endif

    lsu_align u_align (
        .i_st_size   (bus.i_req_funct3[1:0]),
        .i_st_off    (bus.i_req_addr[1:0]),
        .i_st_wdata  (bus.i_req_wdata),
        .o_st_m8     (w_m8),
        .o_st_d64    (w_d64),
        .i_ld_funct3 (funct3_q),
        .i_ld_off    (off_q),
        .i_ld_w0     (w_ld_w0),
        .i_ld_w1     (w_ld_w1),
        .o_ld_data   (w_ld_data)
    );

    assign w_split = (w_m8[7:4] != 4'b0000);

    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_bmask_d = 4'b0000;          // lanes only enabled while in ACC0/ACC1
        mem_wren_d  = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_d     = split_q;
        hi_mask_d   = hi_mask_q;
        hi_data_d   = hi_data_q;
        word0_d     = word0_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_req_valid) begin
                    store_d     = bus.i_req_store;
                    funct3_d    = bus.i_req_funct3;
                    off_d       = bus.i_req_addr[1:0];
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    if (bus.i_req_funct3[1:0] == SZ_X) begin
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end
`ifndef LSU_MISALIGN_SPLIT_EN
                    else if (w_split) begin
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end
`endif
                    else begin
                        // Memory outputs are registered so word0 appears in ACC0.
                        state_d     = ACC0;
                        mem_addr_d  = {bus.i_req_addr[ADDR_W-1:2], 2'b00};
                        mem_bmask_d = w_m8[3:0];
                        mem_wdata_d = w_d64[31:0];
                        mem_wren_d  = bus.i_req_store;
`ifdef LSU_MISALIGN_SPLIT_EN
                        split_d     = w_split;
                        hi_mask_d   = w_m8[7:4];
                        hi_data_d   = w_d64[63:32];
`endif
                    end
                end
            end
            ACC0: begin
                state_d = store_q ? RESP : DONE;
`ifdef LSU_MISALIGN_SPLIT_EN
                if (split_q) begin
                    state_d     = ACC1;
                    mem_addr_d  = mem_addr_q + ADDR_W'(4);   // wraps at top of memory
                    mem_bmask_d = hi_mask_q;
                    mem_wdata_d = hi_data_q;
                    mem_wren_d  = store_q;
                end
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACC1: begin
                word0_d = bus.i_mem_rdata;   // read data of the ACC0 address
                state_d = store_q ? RESP : DONE;
            end
`endif
            DONE: begin
                rsp_rdata_d = w_ld_data;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_bmask_q <= 4'b0000;
            mem_wren_q  <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q     <= 1'b0;
            hi_mask_q   <= 4'b0000;
            hi_data_q   <= 32'h0000_0000;
            word0_q     <= 32'h0000_0000;
`endif
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_bmask_q <= mem_bmask_d;
            mem_wren_q  <= mem_wren_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q     <= split_d;
            hi_mask_q   <= hi_mask_d;
            hi_data_q   <= hi_data_d;
            word0_q     <= word0_d;
`endif
        end
    end

    assign bus.o_req_ready = (state_q == IDLE);
    assign bus.o_rsp_valid = (state_q == RESP);
    assign bus.o_rsp_rdata = rsp_rdata_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign bus.o_mem_bmask = mem_bmask_q;
    assign bus.o_mem_wren  = mem_wren_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_ctrl
//  Description : Self-checking bench for lsu_ctrl. Emulates the data memory,
//                keeps a byte-addressed reference memory and predicts each
//                response (data, error, latency, write count) from it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int ADDR_W    = 11;
    localparam int MEM_BYTES = 1 << ADDR_W;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- data memory emulation ----------------
    logic [31:0]       mem_w [MEM_BYTES/4];
    logic [7:0]        ref_mem [MEM_BYTES];
    int                wr_cnt = 0;
    logic [ADDR_W-1:0] wr_addr_log [$];
    logic [3:0]        wr_mask_log [$];
    logic [31:0]       wr_data_log [$];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.o_mem_wren) begin
            mem_w[bus.o_mem_addr[ADDR_W-1:2]] <= merge(mem_w[bus.o_mem_addr[ADDR_W-1:2]],
                                                       bus.o_mem_wdata, bus.o_mem_bmask);
            wr_cnt <= wr_cnt + 1;
            wr_addr_log.push_back(bus.o_mem_addr);
            wr_mask_log.push_back(bus.o_mem_bmask);
            wr_data_log.push_back(bus.o_mem_wdata);
        end
        bus.i_mem_rdata <= mem_w[bus.o_mem_addr[ADDR_W-1:2]];
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit crosses(input logic [1:0] sz, input logic [ADDR_W-1:0] a);
        return (int'(a[1:0]) + nbytes(sz)) > 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [ADDR_W-1:0] a);
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = nbytes(f3[1:0]);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(a) + i) % MEM_BYTES];
        if (n == 1 && !f3[2] && v[7])  v[31:8]  = 24'hFFFFFF;
        if (n == 2 && !f3[2] && v[15]) v[31:16] = 16'hFFFF;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                             input logic [31:0] wd, input int max_bytes);
        int n;
        n = nbytes(f3[1:0]);
        if (max_bytes < n) n = max_bytes;
        for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % MEM_BYTES] = wd[8*i +: 8];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input string tag, input int idx, input logic [31:0] e_addr,
                               input logic [3:0] e_mask, input logic [31:0] e_data);
        logic [31:0] a, m, d;
        a = 32'hxxxxxxxx; m = 32'hxxxxxxxx; d = 32'hxxxxxxxx;
        if (wr_addr_log.size() > idx) begin
            a = 32'(wr_addr_log[idx]);
            m = 32'(wr_mask_log[idx]);
            d = wr_data_log[idx];
        end
        check({tag, " waddr"}, a, e_addr);
        check({tag, " wmask"}, m, 32'(e_mask));
        check({tag, " wdata"}, d, e_data);
    endtask

    task automatic clear_log();
        wr_addr_log.delete();
        wr_mask_log.delete();
        wr_data_log.delete();
    endtask

    // One full transaction with prediction; stall = cycles i_rsp_ready held low.
    task automatic do_req(input bit st, input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                          input logic [31:0] wd, input int stall, input string tag);
        bit          e_err, sp;
        int          e_lat, e_wr, lat, w, wr0;
        logic [31:0] e_rd;
        sp    = crosses(f3[1:0], a);
        e_err = (f3[1:0] == 2'b11) || (!SPLIT_EN && sp);
        e_lat = e_err ? 1 : st ? (sp ? 3 : 2) : (sp ? 4 : 3);
        e_wr  = (e_err || !st) ? 0 : (sp ? 2 : 1);
        e_rd  = (e_err || st) ? 32'h0 : ref_load(f3, a);

        w = 0;
        while (!bus.o_req_ready && w < 20) begin @(posedge clk); #1; w++; end
        check({tag, " req_ready"}, 32'(bus.o_req_ready), 32'd1);
        wr0 = wr_cnt;
        bus.i_req_valid  = 1'b1;
        bus.i_req_store  = st;
        bus.i_req_funct3 = f3;
        bus.i_req_addr   = a;
        bus.i_req_wdata  = wd;
        @(posedge clk); #1;
        bus.i_req_valid  = 1'b0;
        lat = 1;
        while (!bus.o_rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check({tag, " latency"}, 32'(lat), 32'(e_lat));
        check({tag, " err"},     32'(bus.o_rsp_err), 32'(e_err));
        check({tag, " rdata"},   bus.o_rsp_rdata, e_rd);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, 32'(bus.o_rsp_valid), 32'd1);
            check({tag, " hold ready"}, 32'(bus.o_req_ready), 32'd0);
            check({tag, " hold rdata"}, bus.o_rsp_rdata, e_rd);
            check({tag, " hold err"},   32'(bus.o_rsp_err), 32'(e_err));
        end
        bus.i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_rsp_ready = 1'b0;
        check({tag, " writes"}, 32'(wr_cnt - wr0), 32'(e_wr));
        if (st && !e_err) ref_store(f3, a, wd, 4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr0;
        logic [31:0] exp_w;
        for (int i = 0; i < MEM_BYTES/4; i++) mem_w[i] = 32'h0;
        for (int i = 0; i < MEM_BYTES; i++)   ref_mem[i] = 8'h00;
        bus.i_req_valid  = 1'b0;
        bus.i_req_store  = 1'b0;
        bus.i_req_funct3 = 3'b000;
        bus.i_req_addr   = '0;
        bus.i_req_wdata  = 32'h0;
        bus.i_rsp_ready  = 1'b0;

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        check("rst req_ready", 32'(bus.o_req_ready), 32'd1);
        check("rst rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        check("rst rsp_err",   32'(bus.o_rsp_err),   32'd0);
        check("rst rsp_rdata", bus.o_rsp_rdata,      32'h0);
        check("rst mem_wren",  32'(bus.o_mem_wren),  32'd0);
        check("rst mem_bmask", 32'(bus.o_mem_bmask), 32'd0);
        check("rst mem_addr",  32'(bus.o_mem_addr),  32'd0);
        check("rst mem_wdata", bus.o_mem_wdata,      32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- directed ----
        clear_log();
        do_req(1'b1, SW, 11'h00C, 32'hDEADBEEF, 0, "SW 00C");
        check_write("SW 00C", 0, 32'h00C, 4'b1111, 32'hDEADBEEF);
        do_req(1'b0, LW, 11'h00C, 32'h0, 0, "LW 00C");
        check("LW 00C value", bus.o_rsp_rdata, 32'hDEADBEEF);

        clear_log();
        do_req(1'b1, SB, 11'h00D, 32'h12345678, 0, "SB 00D");
        check_write("SB 00D", 0, 32'h00C, 4'b0010, 32'h00007800);
        do_req(1'b0, LB, 11'h00D, 32'h0, 0, "LB 00D");

        do_req(1'b1, SB, 11'h020, 32'h000000F0, 0, "SB 020");
        do_req(1'b0, LBU, 11'h020, 32'h0, 0, "LBU 020");
        do_req(1'b0, LB,  11'h020, 32'h0, 0, "LB 020");

        clear_log();
        do_req(1'b1, SH, 11'h012, 32'h0000ABCD, 0, "SH 012");
        check_write("SH 012", 0, 32'h010, 4'b1100, 32'hABCD0000);
        do_req(1'b0, LH,  11'h012, 32'h0, 0, "LH 012");
        do_req(1'b0, LHU, 11'h012, 32'h0, 0, "LHU 012");

        clear_log();
        do_req(1'b1, SW, 11'h015, 32'hCAFEF00D, 0, "SW 015");
        if (SPLIT_EN) begin
            check_write("SW 015 w0", 0, 32'h014, 4'b1110, 32'hFEF00D00);
            check_write("SW 015 w1", 1, 32'h018, 4'b0001, 32'h000000CA);
        end
        do_req(1'b0, LW, 11'h015, 32'h0, 0, "LW 015");

        clear_log();
        do_req(1'b1, SW, 11'h7FE, 32'h11223344, 0, "SW 7FE");
        if (SPLIT_EN) begin
            check_write("SW 7FE w0", 0, 32'h7FC, 4'b1100, 32'h33440000);
            check_write("SW 7FE w1", 1, 32'h000, 4'b0011, 32'h00001122);
        end
        do_req(1'b0, LW, 11'h7FE, 32'h0, 0, "LW 7FE");

        do_req(1'b1, 3'b011, 11'h030, 32'h99999999, 0, "S sz11");
        do_req(1'b0, 3'b111, 11'h00C, 32'h0, 0, "L sz11");
        do_req(1'b0, LW, 11'h00C, 32'h0, 3, "LW stall");

        // ---- reset in the middle of a store ----
        wr0 = wr_cnt;
        bus.i_req_valid  = 1'b1;
        bus.i_req_store  = 1'b1;
        bus.i_req_funct3 = SW;
        bus.i_req_addr   = SPLIT_EN ? 11'h101 : 11'h100;
        bus.i_req_wdata  = 32'h55667788;
        @(posedge clk); #1;
        bus.i_req_valid  = 1'b0;
        if (SPLIT_EN) begin
            @(posedge clk); #1;             // word0 written, now in second-word phase
            ref_store(SW, 11'h101, 32'h55667788, 3);
        end
        rst_n = 1'b0;
        #1;
        check("midrst wren",      32'(bus.o_mem_wren),  32'd0);
        check("midrst req_ready", 32'(bus.o_req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("midrst writes",    32'(wr_cnt - wr0),    SPLIT_EN ? 32'd1 : 32'd0);
        check("midrst rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, LW, 11'h100, 32'h0, 0, "LW after rst");

        // ---- randomized ----
        for (int n = 0; n < 200; n++) begin
            bit               st;
            logic [2:0]       f3;
            logic [ADDR_W-1:0] a;
            st = 1'($urandom_range(0, 1));
            f3[2]   = 1'($urandom_range(0, 1));
            f3[1:0] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a = ($urandom_range(0, 3) == 0) ? ADDR_W'(11'h7F8 + $urandom_range(0, 7))
                                            : ADDR_W'($urandom_range(0, 63));
            do_req(st, f3, a, $urandom, $urandom_range(0, 2), "rand");
        end

        // ---- final memory image against reference ----
        for (int i = 0; i < MEM_BYTES/4; i++) begin
            exp_w = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
            check("mem image", mem_w[i], exp_w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
